// File: rtl/led_pkg.sv
// led_pkg: mode/direction encodings, reset pattern and the one-step LED rule
// shared by led_pingpong.
package led_pkg;

    typedef enum logic {MODE_ROT_R = 1'b0, MODE_BOUNCE = 1'b1} mode_e;
    typedef enum logic {DIR_L = 1'b0, DIR_R = 1'b1} dir_e;

    localparam logic [7:0] LED_INIT = 8'h01;

    typedef struct packed {
        logic [7:0] led;
        dir_e       dir;
    } step_t;

    // Bounce reflects off either end so the lit LED never leaves the bar.
    function automatic step_t next_step(input logic [7:0] led, input dir_e dir, input mode_e mode);
        step_t s;
        s.dir = (mode == MODE_ROT_R)      ? DIR_R :
                (dir == DIR_L && led[7])  ? DIR_R :
                (dir == DIR_R && led[0])  ? DIR_L : dir;
        s.led = (mode == MODE_ROT_R)      ? {led[0], led[7:1]} :
                (dir == DIR_L && led[7])  ? 8'h40 :
                (dir == DIR_R && led[0])  ? 8'h02 :
                (dir == DIR_R)            ? led >> 1 : led << 1;
        return s;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchronizer, stability debouncer and single-cycle
// press pulse for one active-low push button.
module key_debounce #(
    parameter int DEB_CYC = 1_000_000
) (
    input  logic clk_50m,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CW = $clog2(DEB_CYC);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYC - 1);

    logic          r_s1, r_s2, r_lvl, r_press;
    logic [CW-1:0] r_cnt;
    logic          w_diff, w_accept;

    assign w_diff   = r_s2 != r_lvl;
    assign w_accept = w_diff && r_cnt == DEB_LAST;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_s1    <= 1'b1;
            r_s2    <= 1'b1;
            r_lvl   <= 1'b1;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_s1    <= key_n;
            r_s2    <= r_s1;
            r_cnt   <= (w_diff && !w_accept) ? r_cnt + 1'b1 : '0;
            r_lvl   <= w_accept ? r_s2 : r_lvl;
            r_press <= w_accept && !r_s2;
        end
    end

    assign press = r_press;

endmodule

// File: rtl/led_pingpong.sv
// led_pingpong: one-hot LED walker with rotate-right and bounce modes,
// stepped by a tick enable and controlled by debounced mode/pause keys.
module led_pingpong
    import led_pkg::*;
#(
    parameter int STEP_CYC = 12_500_000,
    parameter int DEB_CYC  = 1_000_000
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic       key_mode_n,
    input  logic       key_pause_n,
    output logic [7:0] led,
    output logic       dir,
    output logic       mode,
    output logic       paused
);

    localparam int SW = $clog2(STEP_CYC);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYC - 1);

    logic          w_mode_press, w_pause_press, w_tick;
    logic [SW-1:0] r_cnt;
    logic [7:0]    r_led;
    dir_e          r_dir;
    mode_e         r_mode;
    logic          r_paused;
    step_t         w_next;

    key_debounce #(.DEB_CYC(DEB_CYC)) u_key_mode (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .key_n   (key_mode_n),
        .press   (w_mode_press)
    );

    key_debounce #(.DEB_CYC(DEB_CYC)) u_key_pause (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .key_n   (key_pause_n),
        .press   (w_pause_press)
    );

    assign w_tick = !r_paused && r_cnt == STEP_LAST;
    assign w_next = next_step(r_led, r_dir, r_mode);

    // A press in a tick cycle lets the tick use the old mode; leaving bounce forces dir right.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_led    <= LED_INIT;
            r_dir    <= DIR_R;
            r_mode   <= MODE_ROT_R;
            r_paused <= 1'b0;
        end else begin
            r_cnt    <= (r_paused || w_tick) ? '0 : r_cnt + 1'b1;
            r_led    <= w_tick ? w_next.led : r_led;
            r_dir    <= (w_mode_press && r_mode == MODE_BOUNCE) ? DIR_R : w_tick ? w_next.dir : r_dir;
            r_mode   <= w_mode_press ? mode_e'(~r_mode) : r_mode;
            r_paused <= r_paused ^ w_pause_press;
        end
    end

    assign led    = r_led;
    assign dir    = r_dir;
    assign mode   = r_mode;
    assign paused = r_paused;

endmodule

// File: tb/tb_led_pingpong.sv
// tb_led_pingpong: table vectors, directed corner sequences and random key
// traffic checked every cycle against a position/direction reference model.
module tb_led_pingpong;

    localparam int STEP = 4;
    localparam int DEB  = 8;

    logic       clk_50m = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_mode_n = 1'b1;
    logic       key_pause_n = 1'b1;
    logic [7:0] led;
    logic       dir, mode, paused;

    int n_tests = 0;
    int n_fail = 0;

    int ecount, m_pos, m_next;
    bit m_dir, m_mode, m_paused;
    int tq_mode[$];
    int tq_pause[$];

    typedef struct {
        int         n;
        int         mlen;
        int         plen;
        logic [7:0] led;
        logic       dir;
        logic       mode;
        logic       paused;
    } vec_t;
    vec_t tbl[7];

    led_pingpong #(.STEP_CYC(STEP), .DEB_CYC(DEB)) dut (
        .clk_50m     (clk_50m),
        .rst_n       (rst_n),
        .key_mode_n  (key_mode_n),
        .key_pause_n (key_pause_n),
        .led         (led),
        .dir         (dir),
        .mode        (mode),
        .paused      (paused)
    );

    always #5 clk_50m = ~clk_50m;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t edge=%0d)", name, got, exp, $time, ecount);
        end
    endtask

    task automatic model_reset();
        ecount = 0;
        m_pos = 0;
        m_dir = 1'b1;
        m_mode = 1'b0;
        m_paused = 1'b0;
        m_next = STEP;
        tq_mode.delete();
        tq_pause.delete();
    endtask

    // Position 0..7 is the lit bit; a tick moves it, a press flips a flag at its effective edge.
    task automatic model_edge();
        bit tk, mp, pp;
        tk = !m_paused && ecount == m_next;
        mp = tq_mode.size() > 0 && tq_mode[0] == ecount;
        pp = tq_pause.size() > 0 && tq_pause[0] == ecount;
        if (mp) void'(tq_mode.pop_front());
        if (pp) void'(tq_pause.pop_front());
        if (tk) begin
            m_next += STEP;
            if (!m_mode) m_pos = (m_pos + 7) % 8;
            else if (m_dir) begin
                if (m_pos == 0) begin m_dir = 1'b0; m_pos = 1; end
                else m_pos--;
            end else begin
                if (m_pos == 7) begin m_dir = 1'b1; m_pos = 6; end
                else m_pos++;
            end
        end
        if (mp) begin
            m_mode = !m_mode;
            if (!m_mode) m_dir = 1'b1;
        end
        if (pp) begin
            m_paused = !m_paused;
            if (!m_paused) m_next = ecount + STEP;
        end
    endtask

    task automatic cyc1();
        @(posedge clk_50m);
        ecount++;
        model_edge();
        @(negedge clk_50m);
        chk("state", {21'd0, led, dir, mode, paused}, {21'd0, 8'(1 << m_pos), m_dir, m_mode, m_paused});
    endtask

    // Both keys drop together; a low longer than DEB cycles is a press taking effect DEB+3 edges later.
    task automatic key_evt(input int mlen, input int plen, input int n);
        if (mlen > DEB) tq_mode.push_back(ecount + DEB + 3);
        if (plen > DEB) tq_pause.push_back(ecount + DEB + 3);
        for (int i = 0; i < n; i++) begin
            key_mode_n = !(i < mlen);
            key_pause_n = !(i < plen);
            cyc1();
        end
        key_mode_n = 1'b1;
        key_pause_n = 1'b1;
    endtask

    function automatic int pick_len(input int k);
        return (k == 0) ? 0 : (k == 1) ? int'($urandom_range(1, DEB - 1)) : int'($urandom_range(DEB + 1, 3 * DEB));
    endfunction

    initial begin
        bit pm, pp;
        int lm, lp;
        tbl[0] = '{3,  0,  0,  8'h01, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1,  0,  0,  8'h80, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{4,  0,  0,  8'h40, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{4,  0,  0,  8'h20, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{18, 5,  0,  8'h02, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{24, 12, 0,  8'h08, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{24, 0,  12, 8'h01, 1'b1, 1'b1, 1'b1};

        model_reset();
        repeat (2) @(negedge clk_50m);
        chk("reset_vals", {21'd0, led, dir, mode, paused}, {21'd0, 8'h01, 1'b1, 1'b0, 1'b0});
        rst_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            key_evt(tbl[v].mlen, tbl[v].plen, tbl[v].n);
            chk($sformatf("vec%0d", v), {21'd0, led, dir, mode, paused},
                {21'd0, tbl[v].led, tbl[v].dir, tbl[v].mode, tbl[v].paused});
        end

        key_evt(0, 12, 24);
        chk("bounce_right_wall", {23'd0, led, dir}, {23'd0, 8'h08, 1'b0});
        repeat (15) cyc1();
        chk("at_left_end", {23'd0, led, dir}, {23'd0, 8'h80, 1'b0});

        key_evt(0, 12, 24);
        chk("paused_at_20", {22'd0, led, dir, paused}, {22'd0, 8'h20, 1'b1, 1'b1});
        repeat (12) cyc1();
        chk("pause_hold_3step", {24'd0, led}, {24'd0, 8'h20});
        key_pause_n = 1'b0;
        tq_pause.push_back(ecount + DEB + 3);
        repeat (12) cyc1();
        key_pause_n = 1'b1;
        repeat (2) cyc1();
        chk("resume_wait", {24'd0, led}, {24'd0, 8'h20});
        cyc1();
        chk("resume_step", {24'd0, led}, {24'd0, 8'h10});
        repeat (DEB + 4) cyc1();

        for (int g = 0; g < STEP && ((ecount + DEB + 3 - m_next) % STEP) != 0; g++) cyc1();
        key_mode_n = 1'b0;
        tq_mode.push_back(ecount + DEB + 3);
        repeat (DEB + 3) cyc1();
        chk("press_on_tick", {22'd0, led, dir, mode}, {22'd0, 8'h04, 1'b1, 1'b0});
        cyc1();
        key_mode_n = 1'b1;
        repeat (STEP - 1) cyc1();
        chk("new_mode_tick", {24'd0, led}, {24'd0, 8'h02});
        repeat (DEB + 4) cyc1();

        pm = m_mode;
        pp = m_paused;
        key_evt(12, 12, 24);
        chk("both_toggle", {30'd0, mode, paused}, {30'd0, !pm, !pp});

        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 9)) cyc1();
            else begin
                lm = pick_len(int'($urandom_range(0, 2)));
                lp = pick_len(int'($urandom_range(0, 2)));
                key_evt(lm, lp, ((lm > lp) ? lm : lp) + DEB + 4);
            end
        end

        if (!m_mode || !m_paused)
            key_evt(m_mode ? 0 : 12, m_paused ? 0 : 12, 24);
        chk("pre_rst_state", {30'd0, mode, paused}, {30'd0, 1'b1, 1'b1});
        @(posedge clk_50m);
        #3 rst_n = 1'b0;
        #1 chk("async_rst", {21'd0, led, dir, mode, paused}, {21'd0, 8'h01, 1'b1, 1'b0, 1'b0});
        repeat (3) @(negedge clk_50m);
        chk("rst_held", {21'd0, led, dir, mode, paused}, {21'd0, 8'h01, 1'b1, 1'b0, 1'b0});
        rst_n = 1'b1;
        model_reset();
        repeat (STEP - 1) cyc1();
        chk("rel_hold", {24'd0, led}, {24'd0, 8'h01});
        cyc1();
        chk("rel_first_tick", {24'd0, led}, {24'd0, 8'h80});
        repeat (3 * STEP) cyc1();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
